// File: rtl/da_spi_cfg_slave.sv
// SPI config responder: decodes {instr, 1-4 data bytes} frames under CS into a 16x32 shadow file.
// Optional readback of the shadow file on SPI_SDO when DA_SLAVE_READBACK_EN is defined.
module da_spi_cfg_slave #(
    parameter int          SYNC_STAGES = 2,
    // Two bits per address hold (bytes-1). This value encodes
    // a0=1, a1..a2=2, a3=4, a4=3, a5..a9=2, aA..aB=4, aC=3, aD..aF=2 bytes.
    parameter logic [31:0] WIDTH_TABLE = 32'h56F5_56D4
) (
    input  logic        GCLK,
    input  logic        reset,
    input  logic        SPI_SCLK,
    input  logic        SPI_CS,
    input  logic        SPI_SDI,
    output logic        SPI_SDO,
    output logic        REG_WE,
    output logic [3:0]  REG_ADDR,
    output logic [31:0] REG_DATA,
    input  logic [3:0]  RD_ADDR,
    output logic [31:0] RD_DATA,
    output logic        FRAME_ERR,
    output logic        BUSY
);

    typedef enum logic [2:0] {S_IDLE, S_INSTR, S_DATA, S_SKIP, S_RDATA} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sclk_sync, cs_sync, sdi_sync;
    logic                   sclk_d;
    logic                   sclk_s, cs_s, sdi_s, sclk_rise;
    logic [5:0]             bit_cnt, nbits, nbits_dec;
    logic [3:0]             addr, ib_addr;
    logic [31:0]            acc, acc_nxt;
    logic [7:0]             ib;
    logic [1:0]             nb_m1;
    logic                   bad_instr;
    logic [31:0]            shadow [16];

    assign sclk_s    = sclk_sync[SYNC_STAGES-1];
    assign cs_s      = cs_sync[SYNC_STAGES-1];
    assign sdi_s     = sdi_sync[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_d;
    assign acc_nxt   = {acc[30:0], sdi_s};
    assign ib        = acc_nxt[7:0];
    assign ib_addr   = ib[4:1];
    assign nb_m1     = WIDTH_TABLE[{ib_addr, 1'b0} +: 2];
    assign nbits_dec = {1'b0, nb_m1, 3'b000} + 6'd8;
`ifdef DA_SLAVE_READBACK_EN
    assign bad_instr = (ib[6:5] != 2'b00) | ib[0];
`else
    assign bad_instr = (ib[6:5] != 2'b00) | ib[0] | ib[7];
`endif

    assign RD_DATA = shadow[RD_ADDR];
    assign BUSY    = ((state == S_INSTR) && (bit_cnt != 6'd0)) || (state == S_DATA) || (state == S_RDATA);

`ifdef DA_SLAVE_READBACK_EN
    logic [31:0] rd_sh;
    logic        sdo_q;
    logic        sclk_fall;
    assign sclk_fall = ~sclk_s & sclk_d;
    assign SPI_SDO   = sdo_q;
`else
    assign SPI_SDO = 1'b0;
`endif

    always_ff @(posedge GCLK) begin
        if (!reset) begin
            sclk_sync <= '0;
            cs_sync   <= '0;
            sdi_sync  <= '0;
            sclk_d    <= 1'b0;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], SPI_SCLK};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], SPI_CS};
            sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], SPI_SDI};
            sclk_d    <= sclk_s;
        end
    end

    always_ff @(posedge GCLK) begin
        if (!reset) begin
            state     <= S_IDLE;
            bit_cnt   <= '0;
            nbits     <= '0;
            addr      <= '0;
            acc       <= '0;
            REG_WE    <= 1'b0;
            REG_ADDR  <= '0;
            REG_DATA  <= '0;
            FRAME_ERR <= 1'b0;
            for (int i = 0; i < 16; i++) shadow[i] <= '0;
`ifdef DA_SLAVE_READBACK_EN
            rd_sh     <= '0;
            sdo_q     <= 1'b0;
`endif
        end else begin
            REG_WE    <= 1'b0;
            FRAME_ERR <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!cs_s) begin
                        state   <= S_INSTR;
                        bit_cnt <= '0;
                        acc     <= '0;
                    end
                end
                S_INSTR: begin
                    // CS release with no instruction bits is a clean frame boundary.
                    if (cs_s) begin
                        state     <= S_IDLE;
                        FRAME_ERR <= (bit_cnt != 6'd0);
                    end else if (sclk_rise) begin
                        acc     <= acc_nxt;
                        bit_cnt <= bit_cnt + 6'd1;
                        if (bit_cnt == 6'd7) begin
                            bit_cnt <= '0;
                            acc     <= '0;
                            addr    <= ib_addr;
                            nbits   <= nbits_dec;
                            if (bad_instr) begin
                                FRAME_ERR <= 1'b1;
                                state     <= S_SKIP;
                            end
`ifdef DA_SLAVE_READBACK_EN
                            else if (ib[7]) begin
                                state <= S_RDATA;
                                rd_sh <= shadow[ib_addr] << (6'd32 - nbits_dec);
                            end
`endif
                            else begin
                                state <= S_DATA;
                            end
                        end
                    end
                end
                S_DATA: begin
                    if (cs_s) begin
                        state     <= S_IDLE;
                        FRAME_ERR <= 1'b1;
                    end else if (sclk_rise) begin
                        acc     <= acc_nxt;
                        bit_cnt <= bit_cnt + 6'd1;
                        if (bit_cnt == nbits - 6'd1) begin
                            shadow[addr] <= acc_nxt;
                            REG_WE       <= 1'b1;
                            REG_ADDR     <= addr;
                            REG_DATA     <= acc_nxt;
                            state        <= S_INSTR;
                            bit_cnt      <= '0;
                            acc          <= '0;
                        end
                    end
                end
`ifdef DA_SLAVE_READBACK_EN
                S_RDATA: begin
                    // SDO advances on falls so each bit is stable before the master's rise.
                    if (cs_s) begin
                        state     <= S_IDLE;
                        FRAME_ERR <= 1'b1;
                        sdo_q     <= 1'b0;
                    end else if (sclk_fall) begin
                        sdo_q <= rd_sh[31];
                        rd_sh <= {rd_sh[30:0], 1'b0};
                    end else if (sclk_rise) begin
                        bit_cnt <= bit_cnt + 6'd1;
                        if (bit_cnt == nbits - 6'd1) begin
                            state   <= S_INSTR;
                            bit_cnt <= '0;
                            sdo_q   <= 1'b0;
                        end
                    end
                end
`endif
                S_SKIP: begin
                    if (cs_s) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_da_spi_cfg_slave.sv
// Randomized SPI frame bench for da_spi_cfg_slave against a byte-level frame model.
module tb_da_spi_cfg_slave;

    logic        GCLK = 1'b0;
    logic        reset = 1'b0;
    logic        SPI_SCLK = 1'b0;
    logic        SPI_CS = 1'b1;
    logic        SPI_SDI = 1'b0;
    logic        SPI_SDO;
    logic        REG_WE;
    logic [3:0]  REG_ADDR;
    logic [31:0] REG_DATA;
    logic [3:0]  RD_ADDR = 4'd0;
    logic [31:0] RD_DATA;
    logic        FRAME_ERR;
    logic        BUSY;

    da_spi_cfg_slave dut (
        .GCLK(GCLK), .reset(reset), .SPI_SCLK(SPI_SCLK), .SPI_CS(SPI_CS), .SPI_SDI(SPI_SDI),
        .SPI_SDO(SPI_SDO), .REG_WE(REG_WE), .REG_ADDR(REG_ADDR), .REG_DATA(REG_DATA),
        .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA), .FRAME_ERR(FRAME_ERR), .BUSY(BUSY)
    );

    always #5 GCLK = ~GCLK;

    int          total = 0;
    int          bad = 0;
    int          nbytes_tbl [16] = '{1, 2, 2, 4, 3, 2, 2, 2, 2, 2, 4, 4, 3, 2, 2, 2};
    logic [31:0] m_shadow [16];
    logic [35:0] obs_q [$];
    logic [35:0] exp_q [$];
    logic [7:0]  win [$];
    int          nextra;
    int          err_cycles;
    int          exp_err;
    bit          sdo_hi;
    logic [31:0] rb_cap;

    task automatic chk(input string tag, input logic [35:0] got, input logic [35:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(negedge GCLK) begin
        if (REG_WE) obs_q.push_back({REG_ADDR, REG_DATA});
        if (FRAME_ERR) err_cycles++;
        if (SPI_SDO) sdo_hi = 1'b1;
    end

    task automatic spi_bit(input logic b);
        @(negedge GCLK);
        SPI_SDI = b;
        repeat (4) @(negedge GCLK);
        rb_cap = {rb_cap[30:0], SPI_SDO};
        SPI_SCLK = 1'b1;
        repeat (4) @(negedge GCLK);
        SPI_SCLK = 1'b0;
    endtask

    task automatic spi_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) spi_bit(b[i]);
    endtask

    // Byte-level frame model: walks the window and predicts writes and error pulses.
    task automatic model_window();
        int          idx;
        int          nb;
        bit          stop;
        logic [7:0]  ib;
        logic [3:0]  a;
        logic [31:0] v;
        exp_q.delete();
        exp_err = 0;
        idx = 0;
        stop = 1'b0;
        while (!stop && idx < win.size()) begin
            ib = win[idx];
            idx++;
            a = ib[4:1];
            nb = nbytes_tbl[a];
            if (ib[6:5] != 2'b00 || ib[0]) begin
                exp_err++;
                stop = 1'b1;
            end
`ifndef DA_SLAVE_READBACK_EN
            else if (ib[7]) begin
                exp_err++;
                stop = 1'b1;
            end
`endif
            else if (idx + nb > win.size()) begin
                exp_err++;
                stop = 1'b1;
            end else begin
                if (!ib[7]) begin
                    v = 0;
                    for (int k = 0; k < nb; k++) v = (v << 8) | 32'(win[idx + k]);
                    m_shadow[a] = v;
                    exp_q.push_back({a, v});
                end
                idx += nb;
            end
        end
        if (!stop && nextra > 0) exp_err++;
    endtask

    task automatic check_shadow(input string tag);
        for (int a = 0; a < 16; a++) begin
            @(negedge GCLK);
            RD_ADDR = 4'(a);
            #1;
            chk($sformatf("%s.rd%0d", tag, a), {4'h0, RD_DATA}, {4'h0, m_shadow[a]});
        end
    endtask

    task automatic run_window(input string tag);
        model_window();
        obs_q.delete();
        err_cycles = 0;
        sdo_hi = 1'b0;
        @(negedge GCLK);
        SPI_CS = 1'b0;
        repeat (8) @(negedge GCLK);
        foreach (win[i]) spi_byte(win[i]);
        for (int i = 0; i < nextra; i++) spi_bit(1'($urandom_range(0, 1)));
        repeat (8) @(negedge GCLK);
        SPI_CS = 1'b1;
        repeat (12) @(negedge GCLK);
        chk({tag, ".nwr"}, 36'(obs_q.size()), 36'(exp_q.size()));
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            chk($sformatf("%s.wr%0d", tag, i), obs_q[i], exp_q[i]);
        chk({tag, ".err"}, 36'(err_cycles), 36'(exp_err));
        chk({tag, ".busy"}, {35'h0, BUSY}, 36'h0);
`ifndef DA_SLAVE_READBACK_EN
        chk({tag, ".sdo"}, {35'h0, sdo_hi}, 36'h0);
`endif
        check_shadow(tag);
    endtask

    task automatic rand_window();
        int         nfr;
        int         r;
        int         nb;
        logic [3:0] a;
        win.delete();
        nfr = $urandom_range(1, 3);
        for (int f = 0; f < nfr; f++) begin
            r = $urandom_range(0, 9);
            a = 4'($urandom_range(0, 15));
            nb = nbytes_tbl[a];
            if (r == 0) begin
                win.push_back(8'($urandom) | 8'h01);
                win.push_back(8'($urandom));
            end else begin
                win.push_back({(r == 1), 2'b00, a, 1'b0});
                for (int k = 0; k < nb; k++) win.push_back(8'($urandom));
            end
        end
        nextra = 0;
        if ($urandom_range(0, 3) == 0) begin
            r = $urandom_range(0, 2);
            for (int k = 0; k < r && win.size() > 1; k++) void'(win.pop_back());
            nextra = $urandom_range(1, 7);
        end
    endtask

    initial begin
        for (int a = 0; a < 16; a++) m_shadow[a] = 32'h0;
        repeat (3) @(negedge GCLK);
        chk("rst.we", {35'h0, REG_WE}, 36'h0);
        chk("rst.addr", {32'h0, REG_ADDR}, 36'h0);
        chk("rst.data", {4'h0, REG_DATA}, 36'h0);
        chk("rst.err", {35'h0, FRAME_ERR}, 36'h0);
        chk("rst.busy", {35'h0, BUSY}, 36'h0);
        chk("rst.sdo", {35'h0, SPI_SDO}, 36'h0);
        reset = 1'b1;
        repeat (8) @(negedge GCLK);

        win.delete(); win.push_back(8'h00); win.push_back(8'h02); nextra = 0;
        run_window("t1");

        win.delete();
        win.push_back(8'h02); win.push_back(8'h31); win.push_back(8'hC0);
        win.push_back(8'h06); win.push_back(8'h00); win.push_back(8'h00);
        win.push_back(8'h00); win.push_back(8'h80); nextra = 0;
        run_window("t2");

        win.delete(); win.push_back(8'h06); nextra = 3;
        run_window("t3");

        win.delete();
        win.push_back(8'h21); win.push_back(8'hAA); win.push_back(8'h55);
        win.push_back(8'h00); win.push_back(8'h02); nextra = 0;
        run_window("t4");

        // Reset pulse in the middle of a data word.
        @(negedge GCLK);
        SPI_CS = 1'b0;
        repeat (8) @(negedge GCLK);
        spi_byte(8'h06);
        spi_bit(1'b1);
        spi_bit(1'b0);
        repeat (2) @(negedge GCLK);
        chk("t5.busy_mid", {35'h0, BUSY}, 36'h1);
        reset = 1'b0;
        @(negedge GCLK);
        reset = 1'b1;
        chk("t5.we", {35'h0, REG_WE}, 36'h0);
        chk("t5.addr", {32'h0, REG_ADDR}, 36'h0);
        chk("t5.data", {4'h0, REG_DATA}, 36'h0);
        chk("t5.err", {35'h0, FRAME_ERR}, 36'h0);
        chk("t5.busy", {35'h0, BUSY}, 36'h0);
        for (int a = 0; a < 16; a++) m_shadow[a] = 32'h0;
        SPI_CS = 1'b1;
        repeat (12) @(negedge GCLK);
        check_shadow("t5");
        win.delete(); win.push_back(8'h0A); win.push_back(8'h12); win.push_back(8'h34); nextra = 0;
        run_window("t5b");

        win.delete();
        win.push_back(8'h02); win.push_back(8'h31); win.push_back(8'hC0);
        win.push_back(8'h82); win.push_back(8'h00); win.push_back(8'h00); nextra = 0;
        run_window("t6");
`ifdef DA_SLAVE_READBACK_EN
        chk("t6.rb", {20'h0, rb_cap[15:0]}, 36'h31C0);
`endif

        for (int w = 0; w < 25; w++) begin
            rand_window();
            run_window($sformatf("rnd%0d", w));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
